// File: rtl/reg_file_if.sv
// Bus interface for reg_file: one write port (load/inc/dec/clear) and
// two registered read ports sharing one read strobe.
// The master modport drives requests; the slave modport is the register file.
interface reg_file_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);

  logic             wr_en;
  logic [1:0]       wr_op;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid;
  logic             wr_carry;

  modport master (
    output wr_en, wr_op, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid, wr_carry
  );

  modport slave (
    input  wr_en, wr_op, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid, wr_carry
  );

endinterface

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file with one read-modify-write port
// (load / increment / decrement / clear) and two registered read ports.
// Optional macro REG_FILE_BYPASS_EN: a read of the address being written in
// the same cycle returns the post-op value; without it, the pre-op value.
// Reset is asynchronous and active-low on port 'reset'.
module reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_if.slave    bus
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;
  logic             new_carry;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] rd_data_a_q;
  logic [WIDTH-1:0] rd_data_b_q;
  logic             rd_valid_q;
  logic             wr_carry_q;

  // Compute the post-op value of the addressed register and its wrap flag
  always_comb begin
    old_val   = regs[bus.wr_addr];
    new_val   = old_val;
    new_carry = 1'b0;
    case (op_e'(bus.wr_op))
      OP_LOAD:  new_val = bus.wr_data;
      OP_INC: begin
        new_val   = old_val + WIDTH'(1);
        new_carry = &old_val;
      end
      OP_DEC: begin
        new_val   = old_val - WIDTH'(1);
        new_carry = ~|old_val;
      end
      OP_CLEAR: new_val = '0;
      default:  new_val = old_val;
    endcase
  end

  // Select read sources, optionally forwarding the value being written this cycle
  always_comb begin
    src_a = regs[bus.rd_addr_a];
    src_b = regs[bus.rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (bus.wr_en && (bus.rd_addr_a == bus.wr_addr)) src_a = new_val;
    if (bus.wr_en && (bus.rd_addr_b == bus.wr_addr)) src_b = new_val;
`endif
  end

  // Register array and carry flag update on the write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_carry_q <= 1'b0;
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= new_val;
      wr_carry_q        <= new_carry;
    end
  end

  // Registered read ports; data holds when no read is requested
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_a_q <= src_a;
        rd_data_b_q <= src_b;
      end
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_carry  = wr_carry_q;

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: an 8x8 instance and a 32x16 instance driven with
// directed sequences and random traffic, compared every cycle against an
// array-based reference model. Honours REG_FILE_BYPASS_EN like the design.
module tb_reg_file;

  logic clk;
  logic reset;

  reg_file_if #(.WIDTH(8),  .AW(3)) b8 ();
  reg_file_if #(.WIDTH(16), .AW(5)) b16 ();

  reg_file #(.WIDTH(8),  .DEPTH(8),  .AW(3)) dut8  (.clk(clk), .reset(reset), .bus(b8));
  reg_file #(.WIDTH(16), .DEPTH(32), .AW(5)) dut16 (.clk(clk), .reset(reset), .bus(b16));

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int m8 [8];
  int m16 [32];
  int c8, c16, ea8, eb8, ev8, ea16, eb16, ev16;
  int total, bad;

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_result(input int op, input int old, input int data, input int w);
    int modulus = 1 << w;
    case (op)
      0:       return data % modulus;
      1:       return (old + 1) % modulus;
      2:       return (old - 1 + modulus) % modulus;
      default: return 0;
    endcase
  endfunction

  function automatic int op_carry(input int op, input int old, input int w);
    if (op == 1) return (old == (1 << w) - 1) ? 1 : 0;
    if (op == 2) return (old == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic clear_model();
    foreach (m8[i])  m8[i]  = 0;
    foreach (m16[i]) m16[i] = 0;
    c8 = 0; c16 = 0; ea8 = 0; eb8 = 0; ev8 = 0; ea16 = 0; eb16 = 0; ev16 = 0;
  endtask

  task automatic drive8(input int we, input int op, input int wa, input int wd,
                        input int re, input int ra, input int rb);
    b8.wr_en = 1'(we); b8.wr_op = 2'(op); b8.wr_addr = 3'(wa); b8.wr_data = 8'(wd);
    b8.rd_en = 1'(re); b8.rd_addr_a = 3'(ra); b8.rd_addr_b = 3'(rb);
  endtask

  task automatic drive16(input int we, input int op, input int wa, input int wd,
                         input int re, input int ra, input int rb);
    b16.wr_en = 1'(we); b16.wr_op = 2'(op); b16.wr_addr = 5'(wa); b16.wr_data = 16'(wd);
    b16.rd_en = 1'(re); b16.rd_addr_a = 5'(ra); b16.rd_addr_b = 5'(rb);
  endtask

  // Advance one clock with the currently driven inputs, update the model, compare
  task automatic cycle_and_check();
    int we8 = int'(b8.wr_en), wa8 = int'(b8.wr_addr), re8 = int'(b8.rd_en);
    int we16 = int'(b16.wr_en), wa16 = int'(b16.wr_addr), re16 = int'(b16.rd_en);
    int n8 = 0, nc8 = 0, n16 = 0, nc16 = 0;
    int ra8 = int'(b8.rd_addr_a), rb8 = int'(b8.rd_addr_b);
    int ra16 = int'(b16.rd_addr_a), rb16 = int'(b16.rd_addr_b);
    if (we8 != 0) begin
      n8  = op_result(int'(b8.wr_op), m8[wa8], int'(b8.wr_data), 8);
      nc8 = op_carry(int'(b8.wr_op), m8[wa8], 8);
    end
    if (we16 != 0) begin
      n16  = op_result(int'(b16.wr_op), m16[wa16], int'(b16.wr_data), 16);
      nc16 = op_carry(int'(b16.wr_op), m16[wa16], 16);
    end
    if (re8 != 0) begin
      ea8 = (BYPASS && we8 != 0 && ra8 == wa8) ? n8 : m8[ra8];
      eb8 = (BYPASS && we8 != 0 && rb8 == wa8) ? n8 : m8[rb8];
    end
    if (re16 != 0) begin
      ea16 = (BYPASS && we16 != 0 && ra16 == wa16) ? n16 : m16[ra16];
      eb16 = (BYPASS && we16 != 0 && rb16 == wa16) ? n16 : m16[rb16];
    end
    ev8 = re8; ev16 = re16;
    @(posedge clk);
    #1;
    if (we8 != 0)  begin m8[wa8]   = n8;  c8  = nc8;  end
    if (we16 != 0) begin m16[wa16] = n16; c16 = nc16; end
    check_output("rd_a8",   int'(b8.rd_data_a),  ea8);
    check_output("rd_b8",   int'(b8.rd_data_b),  eb8);
    check_output("valid8",  int'(b8.rd_valid),   ev8);
    check_output("carry8",  int'(b8.wr_carry),   c8);
    check_output("rd_a16",  int'(b16.rd_data_a), ea16);
    check_output("rd_b16",  int'(b16.rd_data_b), eb16);
    check_output("valid16", int'(b16.rd_valid),  ev16);
    check_output("carry16", int'(b16.wr_carry),  c16);
  endtask

  // Drive one instance (0 = 8-bit, 1 = 16-bit), idle the other, run a cycle
  task automatic apply_stimulus(input int dut, input int we, input int op, input int wa,
                                input int wd, input int re, input int ra, input int rb);
    drive8(0, 0, 0, 0, 0, 0, 0);
    drive16(0, 0, 0, 0, 0, 0, 0);
    if (dut == 0) drive8(we, op, wa, wd, re, ra, rb);
    else          drive16(we, op, wa, wd, re, ra, rb);
    cycle_and_check();
  endtask

  task automatic read_all(input int dut);
    int depth = (dut == 0) ? 8 : 32;
    for (int i = 0; i < depth; i++) apply_stimulus(dut, 0, 0, 0, 0, 1, i, depth - 1 - i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_a8"},  int'(b8.rd_data_a),  0);
    check_output({tag, "_b8"},  int'(b8.rd_data_b),  0);
    check_output({tag, "_v8"},  int'(b8.rd_valid),   0);
    check_output({tag, "_c8"},  int'(b8.wr_carry),   0);
    check_output({tag, "_a16"}, int'(b16.rd_data_a), 0);
    check_output({tag, "_b16"}, int'(b16.rd_data_b), 0);
    check_output({tag, "_v16"}, int'(b16.rd_valid),  0);
    check_output({tag, "_c16"}, int'(b16.wr_carry),  0);
  endtask

  // Main sequence: reset, directed scenarios, random traffic, mid-run reset
  initial begin
    total = 0;
    bad   = 0;
    clear_model();
    drive8(0, 0, 0, 0, 0, 0, 0);
    drive16(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk) reset = 1'b1;

    // Load then dual read of the same address
    apply_stimulus(0, 1, 0, 3, 'h5A, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 3, 3);
    check_output("load_a", int'(b8.rd_data_a), 'h5A);
    check_output("load_b", int'(b8.rd_data_b), 'h5A);
    check_output("load_v", int'(b8.rd_valid), 1);

    // Wrap-around on increment and decrement
    apply_stimulus(0, 1, 0, 1, 'hFF, 0, 0, 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, 0, 0);
    check_output("inc_wrap_c", int'(b8.wr_carry), 1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1);
    check_output("inc_wrap_v", int'(b8.rd_data_a), 'h00);
    apply_stimulus(0, 1, 2, 1, 0, 0, 0, 0);
    check_output("dec_wrap_c", int'(b8.wr_carry), 1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1);
    check_output("dec_wrap_v", int'(b8.rd_data_a), 'hFF);
    apply_stimulus(0, 1, 1, 1, 0, 0, 0, 0);
    check_output("inc2_c", int'(b8.wr_carry), 1);
    apply_stimulus(0, 1, 0, 1, 'h10, 0, 0, 0);
    check_output("load_clr_c", int'(b8.wr_carry), 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, 0, 0);
    check_output("inc_nc_c", int'(b8.wr_carry), 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
    check_output("inc_nc_v", int'(b8.rd_data_a), 'h11);

    // Same-cycle write and read of one address
    apply_stimulus(0, 1, 0, 2, 'h07, 0, 0, 0);
    apply_stimulus(0, 1, 0, 2, 'h44, 1, 2, 3);
    check_output("collide_a", int'(b8.rd_data_a), BYPASS ? 'h44 : 'h07);
    check_output("collide_b", int'(b8.rd_data_b), 'h5A);

    // Clear, then idle cycles hold data and drop rd_valid
    apply_stimulus(0, 1, 0, 5, 'h33, 0, 0, 0);
    apply_stimulus(0, 1, 3, 5, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 3, 5);
    check_output("clear_b", int'(b8.rd_data_b), 'h00);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("hold_a", int'(b8.rd_data_a), 'h5A);
    check_output("hold_v", int'(b8.rd_valid), 0);
    read_all(0);

    // Wide instance: wrap of the top register, others untouched
    apply_stimulus(1, 1, 0, 31, 'hFFFF, 0, 0, 0);
    apply_stimulus(1, 1, 1, 31, 0, 0, 0, 0);
    check_output("wide_c", int'(b16.wr_carry), 1);
    apply_stimulus(1, 0, 0, 0, 0, 1, 31, 30);
    check_output("wide_v", int'(b16.rd_data_a), 'h0000);
    read_all(1);

    // Random traffic on both instances, narrow address ranges for collisions
    for (int n = 0; n < 400; n++) begin
      drive8(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      drive16(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              (int'($urandom_range(0, 3)) == 0) ? 'hFFFF : int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
      cycle_and_check();
    end
    read_all(0);
    read_all(1);

    // Asynchronous reset mid-operation with traffic still presented
    drive8(1, 0, 4, 'hA5, 1, 3, 4);
    drive16(1, 0, 7, 'h1234, 1, 31, 7);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("async");
    clear_model();
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    @(negedge clk) reset = 1'b1;
    read_all(0);
    read_all(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data bits per register (2..32).
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 8, number of registers (power of 2, 2..32).
REQ-003 Parameter AW SHALL be: AW, default log2(DEPTH), address width.
REQ-004 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en SHALL be: wr_en  input  1  write-port operation strobe.
REQ-007 Port wr_op SHALL be: wr_op  input  2  00 load, 01 increment, 10 decrement, 11 clear.
REQ-008 Port wr_addr SHALL be: wr_addr  input  AW  target register.
REQ-009 Port wr_data SHALL be: wr_data  input  WIDTH  load value (used only for op 00).
REQ-010 Port rd_en SHALL be: rd_en  input  1  read strobe for both read ports.
REQ-011 Port rd_addr_a and rd_addr_b SHALL be: rd_addr_a/rd_addr_b  input  AW each  read addresses.
REQ-012 Port rd_data_a and rd_data_b SHALL be: rd_data_a/rd_data_b  output  WIDTH each  registered read data.
REQ-013 Port rd_valid SHALL be: rd_valid  output  1  high the cycle after rd_en was sampled high.
REQ-014 Port wr_carry SHALL be: wr_carry  output  1  registered wrap flag of the last inc/dec.

Function
REQ-015 A write with wr_en=1 SHALL update register[wr_addr] at the rising edge; wr_en=0 SHALL hold all registers.
REQ-016 Op 00 SHALL store wr_data; op 11 SHALL store 0.
REQ-017 Op 01 SHALL store (reg+1) mod 2^WIDTH; wr_carry SHALL be 1 when the old value was all-ones, else 0.
REQ-018 Op 10 SHALL store (reg-1) mod 2^WIDTH; wr_carry SHALL be 1 when the old value was 0, else 0.
REQ-019 Ops 00/11 SHALL clear wr_carry; wr_carry SHALL hold when wr_en=0.
REQ-020 Read latency SHALL be exactly 1 cycle: rd_data_a/b reflect rd_addr_a/b sampled with rd_en=1; with rd_en=0 rd_data_a/b SHALL hold.
REQ-021 rd_valid SHALL equal rd_en delayed by one cycle.
REQ-022 Both read ports SHALL be independent; equal addresses on A and B SHALL return identical data.
REQ-023 Read and write in the same cycle to different addresses SHALL not interact.
REQ-024 Read and write to the same address in the same cycle: behaviour per REQ-028/029.

Reset
REQ-025 reset=0 SHALL immediately, without clock, clear every register, rd_data_a, rd_data_b, rd_valid and wr_carry to 0.
REQ-026 Operations presented while reset=0 SHALL be discarded; first operation takes effect at the first rising edge with reset=1.
REQ-027 Reset asserted mid-sequence SHALL lose all pending reads (rd_valid=0) and all register contents.

Configuration
REQ-028 With macro REG_FILE_BYPASS_EN defined, a same-cycle read of the address being written SHALL return the new (post-op) value.
REQ-029 Without REG_FILE_BYPASS_EN, a same-cycle read of the address being written SHALL return the old (pre-op) value.

Verification
REQ-030 Reset: drive reset=0 mid-operation -> all outputs 0 asynchronously; after release, reading every address -> 0x00.
REQ-031 Load/read: write 0x5A to r3, next cycle rd_en with A=3, B=3 -> one cycle later rd_data_a=rd_data_b=0x5A, rd_valid=1.
REQ-032 Wrap: load 0xFF to r1, increment r1 -> r1=0x00, wr_carry=1; decrement r1 -> r1=0xFF, wr_carry=1; increment again -> 0x00, carry=1; load then increment 0x10 -> 0x11, carry=0.
REQ-033 Collision: r2=0x07, same cycle write load 0x44 to r2 and read A=2 -> rd_data_a=0x44 with REG_FILE_BYPASS_EN, 0x07 without.
REQ-034 Clear/hold: r5=0x33, op 11 on r5 -> 0x00; cycles with wr_en=0, rd_en=0 -> all registers and rd_data unchanged, rd_valid=0.
REQ-035 Parameters: WIDTH=16, DEPTH=32 -> write 0xFFFF to r31, increment -> 0x0000, wr_carry=1; other 31 registers unchanged.
